disp_regbus_bridge: RTL and testbench

//  AXI4-Lite slave to display register-bus initiator. Converts single CPU AXI4-Lite

---
 rtl/disp_regbus_bridge_if.sv | 46 ++++
 rtl/disp_regbus_bridge.sv | 129 ++++++++++++
 tb/tb_disp_regbus_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_regbus_bridge_if.sv
// Signal bundle between the AXI4-Lite initiator / display register block and the bridge.
// The slave modport is the bridge's view; master is the surrounding environment's view.
interface disp_regbus_bridge_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  logic [ADDR_W-1:0] WRADDR;
  logic [3:0]        BYTEEN;
  logic              WREN;
  logic [31:0]       WDATA;
  logic [ADDR_W-1:0] RDADDR;
  logic              RDEN;
  logic [31:0]       RDATA;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, RDATA,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, RDATA,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN
  );
endinterface

// File: rtl/disp_regbus_bridge.sv
// AXI4-Lite slave that turns single reads/writes into one-cycle WREN/RDEN strobes on the
// display register bus and returns the registered read data. One transaction at a time.
module disp_regbus_bridge #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                 ACLK,
  input logic                 ARST,
  disp_regbus_bridge_if.slave bus
);

  localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitW,
    StWaitAw,
    StWrIssue,
    StWrResp,
    StRdIssue,
    StRdWait,
    StRdResp
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [31:0]       wdata_q, rdata_q, rdata_d;
  logic [3:0]        wstrb_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              aw_ready, w_ready, ar_ready;
  logic              aw_hs, w_hs, ar_hs;

  assign aw_hs = bus.S_AXI_AWVALID && aw_ready;
  assign w_hs  = bus.S_AXI_WVALID && w_ready;
  assign ar_hs = bus.S_AXI_ARVALID && ar_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    ar_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        // A pending write always beats a same-cycle read.
        ar_ready = !bus.S_AXI_AWVALID && !bus.S_AXI_WVALID;
        if (bus.S_AXI_AWVALID && bus.S_AXI_WVALID) begin
          state_d = StWrIssue;
        end else if (bus.S_AXI_AWVALID) begin
          state_d = StWaitW;
        end else if (bus.S_AXI_WVALID) begin
          state_d = StWaitAw;
        end else if (bus.S_AXI_ARVALID) begin
          state_d = StRdIssue;
        end
      end
      StWaitW: begin
        w_ready = 1'b1;
        if (bus.S_AXI_WVALID) state_d = StWrIssue;
      end
      StWaitAw: begin
        aw_ready = 1'b1;
        if (bus.S_AXI_AWVALID) state_d = StWrIssue;
      end
      StWrIssue: state_d = StWrResp;
      StWrResp: begin
        if (bus.S_AXI_BREADY) state_d = StIdle;
      end
      StRdIssue: begin
        cnt_d   = CntW'(RD_LATENCY - 1);
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          rdata_d = bus.RDATA;
          state_d = StRdResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRdResp: begin
        if (bus.S_AXI_RREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q  <= StIdle;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (aw_hs) awaddr_q <= bus.S_AXI_AWADDR;
      if (ar_hs) araddr_q <= bus.S_AXI_ARADDR;
      if (w_hs) begin
        wdata_q <= bus.S_AXI_WDATA;
        wstrb_q <= bus.S_AXI_WSTRB;
      end
    end
  end

  // Handshake and strobe outputs are silenced while reset is asserted.
  assign bus.S_AXI_AWREADY = aw_ready && !ARST;
  assign bus.S_AXI_WREADY  = w_ready && !ARST;
  assign bus.S_AXI_ARREADY = ar_ready && !ARST;
  assign bus.S_AXI_BVALID  = (state_q == StWrResp) && !ARST;
  assign bus.S_AXI_RVALID  = (state_q == StRdResp) && !ARST;
  assign bus.S_AXI_BRESP   = 2'b00;
  assign bus.S_AXI_RRESP   = 2'b00;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.WREN          = (state_q == StWrIssue) && !ARST;
  assign bus.RDEN          = (state_q == StRdIssue) && !ARST;
  assign bus.WRADDR        = awaddr_q;
  assign bus.BYTEEN        = wstrb_q;
  assign bus.WDATA         = wdata_q;
  assign bus.RDADDR        = araddr_q;

endmodule

// File: tb/tb_disp_regbus_bridge.sv
// Directed bench for disp_regbus_bridge: write/read paths, ordering, backpressure and reset.
module tb_disp_regbus_bridge;

  logic        aclk = 1'b0;
  logic        arst;
  logic [31:0] rd_value;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 aclk = ~aclk;

  disp_regbus_bridge_if #(.ADDR_W(16)) bus ();

  disp_regbus_bridge #(
    .ADDR_W    (16),
    .RD_LATENCY(1)
  ) dut (
    .ACLK(aclk),
    .ARST(arst),
    .bus (bus.slave)
  );

  // Register block model: data valid only in the cycle after RDEN, garbage otherwise.
  always @(posedge aclk) begin
    bus.RDATA <= bus.RDEN ? rd_value : 32'hBAD0_0BAD;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    step();
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_AWREADY !== 1'b0) begin n_fail++; $display("FAIL rst_awready: got %b exp 0", bus.S_AXI_AWREADY); end
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b exp 0", bus.S_AXI_ARREADY); end
    n_checks++; if (bus.WREN !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b exp 0", bus.WREN); end
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 0", bus.S_AXI_RVALID); end
    n_checks++; if (bus.S_AXI_RDATA !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", bus.S_AXI_RDATA); end
    n_checks++; if (bus.WRADDR !== 16'h0) begin n_fail++; $display("FAIL rst_wraddr: got %h exp 0", bus.WRADDR); end
    step();
    arst = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin n_fail++; $display("FAIL idle_awready: got %b exp 1", bus.S_AXI_AWREADY); end
    n_checks++; if (bus.S_AXI_WREADY !== 1'b1) begin n_fail++; $display("FAIL idle_wready: got %b exp 1", bus.S_AXI_WREADY); end
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin n_fail++; $display("FAIL idle_arready: got %b exp 1", bus.S_AXI_ARREADY); end
    step();
  endtask

  task automatic test_write_same_cycle();
    bus.S_AXI_AWADDR = 16'h0004; bus.S_AXI_WDATA = 32'h0000_0001; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_fail++; $display("FAIL wr_arready_t: got %b exp 0", bus.S_AXI_ARREADY); end
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.WREN !== 1'b1) begin n_fail++; $display("FAIL wr_wren_t1: got %b exp 1", bus.WREN); end
    n_checks++; if (bus.WRADDR !== 16'h0004) begin n_fail++; $display("FAIL wr_wraddr: got %h exp 0004", bus.WRADDR); end
    n_checks++; if (bus.WDATA !== 32'h1) begin n_fail++; $display("FAIL wr_wdata: got %h exp 00000001", bus.WDATA); end
    n_checks++; if (bus.BYTEEN !== 4'hF) begin n_fail++; $display("FAIL wr_byteen: got %h exp f", bus.BYTEEN); end
    n_checks++; if (bus.S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_t1: got %b exp 0", bus.S_AXI_BVALID); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.WREN !== 1'b0) begin n_fail++; $display("FAIL wr_wren_t2: got %b exp 0", bus.WREN); end
    n_checks++; if (bus.S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL wr_bvalid_t2: got %b exp 1", bus.S_AXI_BVALID); end
    n_checks++; if (bus.S_AXI_BRESP !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b exp 00", bus.S_AXI_BRESP); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_t3: got %b exp 0", bus.S_AXI_BVALID); end
    n_checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin n_fail++; $display("FAIL wr_idle_again: got %b exp 1", bus.S_AXI_AWREADY); end
    step();
  endtask

  task automatic test_w_then_aw();
    bus.S_AXI_WDATA = 32'hDEAD_BEEF; bus.S_AXI_WSTRB = 4'h5; bus.S_AXI_WVALID = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_WREADY !== 1'b1) begin n_fail++; $display("FAIL wfirst_wready: got %b exp 1", bus.S_AXI_WREADY); end
    step();
    bus.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      n_checks++; if (bus.S_AXI_WREADY !== 1'b0) begin n_fail++; $display("FAIL waitaw_wready[%0d]: got %b exp 0", i, bus.S_AXI_WREADY); end
      n_checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_fail++; $display("FAIL waitaw_arready[%0d]: got %b exp 0", i, bus.S_AXI_ARREADY); end
      n_checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin n_fail++; $display("FAIL waitaw_awready[%0d]: got %b exp 1", i, bus.S_AXI_AWREADY); end
      n_checks++; if (bus.WREN !== 1'b0) begin n_fail++; $display("FAIL waitaw_wren[%0d]: got %b exp 0", i, bus.WREN); end
      step();
    end
    bus.S_AXI_AWADDR = 16'h1230; bus.S_AXI_AWVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.WREN !== 1'b1) begin n_fail++; $display("FAIL wfirst_wren: got %b exp 1", bus.WREN); end
    n_checks++; if (bus.WRADDR !== 16'h1230) begin n_fail++; $display("FAIL wfirst_wraddr: got %h exp 1230", bus.WRADDR); end
    n_checks++; if (bus.WDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wfirst_wdata: got %h exp deadbeef", bus.WDATA); end
    n_checks++; if (bus.BYTEEN !== 4'h5) begin n_fail++; $display("FAIL wfirst_byteen: got %h exp 5", bus.BYTEEN); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.WREN !== 1'b0) begin n_fail++; $display("FAIL wfirst_wren_once: got %b exp 0", bus.WREN); end
    n_checks++; if (bus.S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL wfirst_bvalid: got %b exp 1", bus.S_AXI_BVALID); end
    step();
  endtask

  task automatic test_read();
    rd_value = 32'h0ABC_D000;
    bus.S_AXI_ARADDR = 16'h0000; bus.S_AXI_ARVALID = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin n_fail++; $display("FAIL rd_arready: got %b exp 1", bus.S_AXI_ARREADY); end
    step();
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.RDEN !== 1'b1) begin n_fail++; $display("FAIL rd_rden_t1: got %b exp 1", bus.RDEN); end
    n_checks++; if (bus.RDADDR !== 16'h0000) begin n_fail++; $display("FAIL rd_rdaddr: got %h exp 0000", bus.RDADDR); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.RDEN !== 1'b0) begin n_fail++; $display("FAIL rd_rden_t2: got %b exp 0", bus.RDEN); end
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_t2: got %b exp 0", bus.S_AXI_RVALID); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid_t3: got %b exp 1", bus.S_AXI_RVALID); end
    n_checks++; if (bus.S_AXI_RDATA !== 32'h0ABC_D000) begin n_fail++; $display("FAIL rd_rdata: got %h exp 0abcd000", bus.S_AXI_RDATA); end
    n_checks++; if (bus.S_AXI_RRESP !== 2'b00) begin n_fail++; $display("FAIL rd_rresp: got %b exp 00", bus.S_AXI_RRESP); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_t4: got %b exp 0", bus.S_AXI_RVALID); end
    step();
  endtask

  task automatic test_backpressure();
    // Write with zero byte enables and a stalled B channel.
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_AWADDR = 16'h00FC; bus.S_AXI_WDATA = 32'hA5A5_A5A5; bus.S_AXI_WSTRB = 4'h0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.WREN !== 1'b1) begin n_fail++; $display("FAIL bp_wren_strb0: got %b exp 1", bus.WREN); end
    n_checks++; if (bus.BYTEEN !== 4'h0) begin n_fail++; $display("FAIL bp_byteen: got %h exp 0", bus.BYTEEN); end
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      n_checks++; if (bus.S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL bp_bvalid[%0d]: got %b exp 1", i, bus.S_AXI_BVALID); end
      n_checks++; if (bus.S_AXI_BRESP !== 2'b00) begin n_fail++; $display("FAIL bp_bresp[%0d]: got %b exp 00", i, bus.S_AXI_BRESP); end
      n_checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin n_fail++; $display("FAIL bp_w_readys[%0d]: got %b exp 000", i, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
      n_checks++; if (bus.WREN !== 1'b0) begin n_fail++; $display("FAIL bp_wren_hold[%0d]: got %b exp 0", i, bus.WREN); end
      step();
    end
    bus.S_AXI_BREADY = 1'b1;
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL bp_bvalid_done: got %b exp 0", bus.S_AXI_BVALID); end
    n_checks++; if (bus.WRADDR !== 16'h00FC) begin n_fail++; $display("FAIL bp_wraddr_hold: got %h exp 00fc", bus.WRADDR); end
    // Read with a stalled R channel.
    bus.S_AXI_RREADY = 1'b0;
    rd_value = 32'h600D_F00D;
    bus.S_AXI_ARADDR = 16'h0010; bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      n_checks++; if (bus.S_AXI_RVALID !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid[%0d]: got %b exp 1", i, bus.S_AXI_RVALID); end
      n_checks++; if (bus.S_AXI_RDATA !== 32'h600D_F00D) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h exp 600df00d", i, bus.S_AXI_RDATA); end
      n_checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin n_fail++; $display("FAIL bp_r_readys[%0d]: got %b exp 000", i, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
      step();
    end
    bus.S_AXI_RREADY = 1'b1;
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL bp_rvalid_done: got %b exp 0", bus.S_AXI_RVALID); end
    n_checks++; if (bus.RDADDR !== 16'h0010) begin n_fail++; $display("FAIL bp_rdaddr_hold: got %h exp 0010", bus.RDADDR); end
    step();
  endtask

  task automatic test_priority();
    rd_value = 32'h0000_00AA;
    bus.S_AXI_AWADDR = 16'h0008; bus.S_AXI_WDATA = 32'h1122_3344; bus.S_AXI_WSTRB = 4'h3;
    bus.S_AXI_ARADDR = 16'h0020;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_fail++; $display("FAIL pri_arready_t: got %b exp 0", bus.S_AXI_ARREADY); end
    n_checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin n_fail++; $display("FAIL pri_awready_t: got %b exp 1", bus.S_AXI_AWREADY); end
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if ({bus.WREN, bus.RDEN} !== 2'b10) begin n_fail++; $display("FAIL pri_strobes_t1: got %b exp 10", {bus.WREN, bus.RDEN}); end
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_fail++; $display("FAIL pri_arready_t1: got %b exp 0", bus.S_AXI_ARREADY); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL pri_bvalid_t2: got %b exp 1", bus.S_AXI_BVALID); end
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_fail++; $display("FAIL pri_arready_t2: got %b exp 0", bus.S_AXI_ARREADY); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin n_fail++; $display("FAIL pri_arready_t3: got %b exp 1", bus.S_AXI_ARREADY); end
    step();
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if ({bus.WREN, bus.RDEN} !== 2'b01) begin n_fail++; $display("FAIL pri_strobes_t4: got %b exp 01", {bus.WREN, bus.RDEN}); end
    n_checks++; if (bus.RDADDR !== 16'h0020) begin n_fail++; $display("FAIL pri_rdaddr: got %h exp 0020", bus.RDADDR); end
    step();
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b1) begin n_fail++; $display("FAIL pri_rvalid: got %b exp 1", bus.S_AXI_RVALID); end
    n_checks++; if (bus.S_AXI_RDATA !== 32'h0000_00AA) begin n_fail++; $display("FAIL pri_rdata: got %h exp 000000aa", bus.S_AXI_RDATA); end
    step();
  endtask

  task automatic test_reset_mid_read();
    rd_value = 32'hFFFF_0000;
    bus.S_AXI_ARADDR = 16'h0030; bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.RDEN !== 1'b1) begin n_fail++; $display("FAIL mrst_rden: got %b exp 1", bus.RDEN); end
    step();
    arst = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL mrst_rvalid_in: got %b exp 0", bus.S_AXI_RVALID); end
    step();
    arst = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL mrst_rvalid_out: got %b exp 0", bus.S_AXI_RVALID); end
    n_checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin n_fail++; $display("FAIL mrst_idle: got %b exp 1", bus.S_AXI_ARREADY); end
    n_checks++; if (bus.S_AXI_RDATA !== 32'h0) begin n_fail++; $display("FAIL mrst_rdata: got %h exp 0", bus.S_AXI_RDATA); end
    rd_value = 32'h1234_5678;
    bus.S_AXI_ARADDR = 16'h0042; bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.RDEN !== 1'b1) begin n_fail++; $display("FAIL mrst_rd2_rden: got %b exp 1", bus.RDEN); end
    n_checks++; if (bus.RDADDR !== 16'h0042) begin n_fail++; $display("FAIL mrst_rd2_rdaddr: got %h exp 0042", bus.RDADDR); end
    step();
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b1) begin n_fail++; $display("FAIL mrst_rd2_rvalid: got %b exp 1", bus.S_AXI_RVALID); end
    n_checks++; if (bus.S_AXI_RDATA !== 32'h1234_5678) begin n_fail++; $display("FAIL mrst_rd2_rdata: got %h exp 12345678", bus.S_AXI_RDATA); end
    step();
    @(negedge aclk);
    n_checks++; if (bus.S_AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL mrst_rd2_done: got %b exp 0", bus.S_AXI_RVALID); end
    step();
  endtask

  initial begin
    arst = 1'b1;
    rd_value = 32'h0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    test_reset();
    test_write_same_cycle();
    test_w_then_aw();
    test_read();
    test_backpressure();
    test_priority();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
